uart_fifo_core: RTL and testbench

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_fifo_core.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// UART core with TX/RX FIFOs, shared oversample tick, runtime-selectable framing.
// Latency: TX frame starts on the second tick after push; RX entry is pushed at mid first stop bit.
// Backpressure: tx_ready drops when the TX FIFO is full; a frame arriving at a full RX FIFO is dropped and flagged.
module uart_fifo_core #(
    parameter int DIV_W    = 16,
    parameter int OVS      = 16,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [4:0]       cfg,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_sn,
    input  logic             rx_sn,
    output logic [7:0]       rx_data,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    input  logic             err_clr
);
    localparam int CW  = $clog2(OVS);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);

    typedef struct packed {
        logic       stop_sel;
        logic       parity_en;
        logic       parity_even;
        logic [1:0] data_len;
    } cfg_t;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_ent_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic [7:0] mask_data(input logic [1:0] len, input logic [7:0] d);
        return d & (8'hFF >> (2'd3 - len));
    endfunction

    function automatic logic par_bit(input logic even, input logic [7:0] d);
        return (^d) ^ ~even;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] len);
        return {1'b0, len} + 3'd4;
    endfunction

    cfg_t cfg_in;
    assign cfg_in = cfg_t'(cfg);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    assign tick = (div_cnt >= baud_div);

    // TX FIFO: extra pointer bit separates full from empty
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [TAW:0] tx_wp, tx_rp;
    logic         tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]   tx_head;
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = ((tx_wp ^ tx_rp) == {1'b1, {TAW{1'b0}}});
    assign tx_head  = tx_mem[tx_rp[TAW-1:0]];
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    rx_ent_t      rx_mem [RX_DEPTH];
    logic [RAW:0] rx_wp, rx_rp;
    logic         rx_empty, rx_full, rx_push, rx_pop, rx_done, ov_set;
    rx_ent_t      rx_head, rx_wdat;
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = ((rx_wp ^ rx_rp) == {1'b1, {RAW{1'b0}}});
    assign rx_head  = rx_mem[rx_rp[RAW-1:0]];
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = rx_done && (!rx_full || rx_pop);
    assign ov_set   = rx_done && rx_full && !rx_pop;
    assign rx_data  = rx_empty ? 8'h00 : rx_head.data;
    assign rx_perr  = !rx_empty && rx_head.perr;
    assign rx_ferr  = !rx_empty && rx_head.ferr;

    state_t          tx_st, tx_st_nxt;
    logic [CW-1:0]   tx_cnt, tx_cnt_nxt;
    logic [2:0]      tx_bit, tx_bit_nxt;
    logic            tx_stop, tx_stop_nxt, tx_ld, tx_ld_nxt, tx_bit_end;
    logic [7:0]      tx_shr, tx_shr_nxt;
    cfg_t            tx_cfg, tx_cfg_nxt;

    always_comb begin
        tx_st_nxt   = tx_st;
        tx_cnt_nxt  = tx_cnt;
        tx_bit_nxt  = tx_bit;
        tx_stop_nxt = tx_stop;
        tx_ld_nxt   = tx_ld;
        tx_shr_nxt  = tx_shr;
        tx_cfg_nxt  = tx_cfg;
        tx_pop      = 1'b0;
        tx_bit_end  = tick && (tx_cnt == LAST);
        if (tick && tx_st != IDLE)
            tx_cnt_nxt = tx_bit_end ? '0 : tx_cnt + CW'(1);
        case (tx_st)
            IDLE: begin
                if (tx_ld) begin
                    if (tick) begin
                        tx_st_nxt  = START;
                        tx_ld_nxt  = 1'b0;
                        tx_cnt_nxt = '0;
                    end
                end else if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_ld_nxt  = 1'b1;
                    tx_cfg_nxt = cfg_in;
                    tx_shr_nxt = mask_data(cfg_in.data_len, tx_head);
                end
            end
            START: if (tx_bit_end) begin
                tx_st_nxt  = DATA;
                tx_bit_nxt = '0;
            end
            DATA: if (tx_bit_end) begin
                if (tx_bit == last_idx(tx_cfg.data_len)) begin
                    tx_st_nxt   = tx_cfg.parity_en ? PARITY : STOP;
                    tx_stop_nxt = 1'b0;
                end else begin
                    tx_bit_nxt = tx_bit + 3'd1;
                end
            end
            PARITY: if (tx_bit_end) begin
                tx_st_nxt   = STOP;
                tx_stop_nxt = 1'b0;
            end
            STOP: if (tx_bit_end) begin
                if (tx_stop != tx_cfg.stop_sel) begin
                    tx_stop_nxt = 1'b1;
                end else if (!tx_empty) begin
                    // chain the next frame straight off the last stop bit
                    tx_pop     = 1'b1;
                    tx_st_nxt  = START;
                    tx_cfg_nxt = cfg_in;
                    tx_shr_nxt = mask_data(cfg_in.data_len, tx_head);
                end else begin
                    tx_st_nxt = IDLE;
                end
            end
            default: tx_st_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (tx_st)
            START:   tx_sn = 1'b0;
            DATA:    tx_sn = tx_shr[tx_bit];
            PARITY:  tx_sn = par_bit(tx_cfg.parity_even, tx_shr);
            default: tx_sn = 1'b1;
        endcase
    end
    assign tx_busy = (tx_st != IDLE) || tx_ld || !tx_empty;

    logic [1:0]    rx_sync;
    logic          rxs;
    state_t        rx_st, rx_st_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shr, rx_shr_nxt;
    logic          rx_pe, rx_pe_nxt, rx_pen, rx_pen_nxt, rx_peven, rx_peven_nxt, rx_samp;
    logic [1:0]    rx_len, rx_len_nxt;
    assign rxs = rx_sync[1];
    assign rx_wdat = '{ferr: ~rxs, perr: rx_pe, data: rx_shr};

    always_comb begin
        rx_st_nxt    = rx_st;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shr_nxt   = rx_shr;
        rx_pe_nxt    = rx_pe;
        rx_pen_nxt   = rx_pen;
        rx_peven_nxt = rx_peven;
        rx_len_nxt   = rx_len;
        rx_done      = 1'b0;
        rx_samp      = tick && (rx_cnt == LAST);
        if (tick && rx_st != IDLE)
            rx_cnt_nxt = rx_samp ? '0 : rx_cnt + CW'(1);
        case (rx_st)
            IDLE: if (!rxs) begin
                rx_st_nxt    = START;
                rx_cnt_nxt   = '0;
                rx_shr_nxt   = '0;
                rx_pe_nxt    = 1'b0;
                rx_pen_nxt   = cfg_in.parity_en;
                rx_peven_nxt = cfg_in.parity_even;
                rx_len_nxt   = cfg_in.data_len;
            end
            START: if (tick && rx_cnt == HALF) begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                rx_st_nxt  = rxs ? IDLE : DATA;
            end
            DATA: if (rx_samp) begin
                rx_shr_nxt[rx_bit] = rxs;
                if (rx_bit == last_idx(rx_len))
                    rx_st_nxt = rx_pen ? PARITY : STOP;
                else
                    rx_bit_nxt = rx_bit + 3'd1;
            end
            PARITY: if (rx_samp) begin
                rx_pe_nxt = rxs ^ par_bit(rx_peven, rx_shr);
                rx_st_nxt = STOP;
            end
            STOP: if (rx_samp) begin
                rx_done   = 1'b1;
                rx_st_nxt = IDLE;
            end
            default: rx_st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            tx_wp      <= '0;
            tx_rp      <= '0;
            rx_wp      <= '0;
            rx_rp      <= '0;
            tx_st      <= IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_stop    <= 1'b0;
            tx_ld      <= 1'b0;
            tx_shr     <= '0;
            tx_cfg     <= '0;
            rx_sync    <= 2'b11;
            rx_st      <= IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shr     <= '0;
            rx_pe      <= 1'b0;
            rx_pen     <= 1'b0;
            rx_peven   <= 1'b0;
            rx_len     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tx_push) tx_wp <= tx_wp + (TAW+1)'(1);
            if (tx_pop)  tx_rp <= tx_rp + (TAW+1)'(1);
            if (rx_push) rx_wp <= rx_wp + (RAW+1)'(1);
            if (rx_pop)  rx_rp <= rx_rp + (RAW+1)'(1);
            tx_st      <= tx_st_nxt;
            tx_cnt     <= tx_cnt_nxt;
            tx_bit     <= tx_bit_nxt;
            tx_stop    <= tx_stop_nxt;
            tx_ld      <= tx_ld_nxt;
            tx_shr     <= tx_shr_nxt;
            tx_cfg     <= tx_cfg_nxt;
            rx_sync    <= {rx_sync[0], rx_sn};
            rx_st      <= rx_st_nxt;
            rx_cnt     <= rx_cnt_nxt;
            rx_bit     <= rx_bit_nxt;
            rx_shr     <= rx_shr_nxt;
            rx_pe      <= rx_pe_nxt;
            rx_pen     <= rx_pen_nxt;
            rx_peven   <= rx_peven_nxt;
            rx_len     <= rx_len_nxt;
            if (ov_set)
                rx_overrun <= 1'b1;
            else if (err_clr)
                rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= tx_data;
        if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_wdat;
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: reset, 8N1/7E1/8O2 framing, loopback, errors, overrun, mid-frame reset.
`timescale 1ns/1ps
module tb_uart_fifo_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [4:0]  cfg;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_busy, tx_sn, rx_sn;
    logic [7:0]  rx_data;
    logic        rx_perr, rx_ferr, rx_valid, rx_ready, rx_overrun, err_clr;
    logic        loop, rx_drv;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    assign rx_sn = loop ? tx_sn : rx_drv;

    uart_fifo_core dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .cfg(cfg),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_sn(tx_sn), .rx_sn(rx_sn),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .err_clr(err_clr)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_byte();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_start(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_sn === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: tx_sn stayed %b, want a 0 start bit", name, tx_sn);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input int nbits, input bit pen,
                            input logic pbit, input logic stop);
        rx_drv = 1'b0; tick(16);
        for (int i = 0; i < nbits; i++) begin rx_drv = d[i]; tick(16); end
        if (pen) begin rx_drv = pbit; tick(16); end
        rx_drv = stop; tick(16);
        rx_drv = 1'b1; tick(24);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        checks++; if (tx_sn !== 1'b1) begin errors++; $display("FAIL reset_tx_sn: got %b want 1", tx_sn); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if ({rx_data, rx_perr, rx_ferr, rx_overrun} !== 11'h0)
            begin errors++; $display("FAIL reset_rx_out: got %h/%b/%b/%b want 0", rx_data, rx_perr, rx_ferr, rx_overrun); end
        rst_n = 1'b1; tick(2);
    endtask

    task automatic test_tx_8n1();
        bit ok, bad;
        logic [9:0] exp;
        cfg = 5'b00011; loop = 1'b1;
        exp = {1'b1, 8'hA5, 1'b0};
        push_byte(8'hA5);
        wait_tx_start("8n1_start", ok);
        if (ok) begin
            for (int b = 0; b < 10; b++) begin
                bad = 1'b0;
                for (int c = 0; c < 16; c++) begin
                    if (tx_sn !== exp[b]) bad = 1'b1;
                    @(negedge clk);
                end
                checks++; if (bad) begin errors++; $display("FAIL 8n1_bit%0d: tx_sn not %b for all 16 clk", b, exp[b]); end
            end
            checks++; if (tx_busy !== 1'b0 || tx_sn !== 1'b1)
                begin errors++; $display("FAIL 8n1_idle: busy=%b sn=%b want 0/1", tx_busy, tx_sn); end
        end
        tick(4);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || rx_perr !== 1'b0 || rx_ferr !== 1'b0)
            begin errors++; $display("FAIL 8n1_loopback: v=%b d=%h p=%b f=%b want 1/a5/0/0", rx_valid, rx_data, rx_perr, rx_ferr); end
        pop_byte();
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00)
            begin errors++; $display("FAIL 8n1_empty: v=%b d=%h want 0/00", rx_valid, rx_data); end
    endtask

    task automatic test_7e1();
        bit ok;
        logic [9:0] cap;
        cfg = 5'b01110; loop = 1'b1;
        push_byte(8'h53);
        wait_tx_start("7e1_start", ok);
        cap = '0;
        if (ok) begin
            tick(8);
            cap[0] = tx_sn;
            for (int k = 1; k < 10; k++) begin tick(16); cap[k] = tx_sn; end
            checks++; if (cap !== 10'b1_0_1010011_0)
                begin errors++; $display("FAIL 7e1_wire: got %b want 1010100110", cap); end
        end
        tick(16);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h53 || rx_perr !== 1'b0)
            begin errors++; $display("FAIL 7e1_loopback: v=%b d=%h p=%b want 1/53/0", rx_valid, rx_data, rx_perr); end
        pop_byte();
        loop = 1'b0;
        rx_frame(8'h53, 7, 1'b1, 1'b1, 1'b1);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h53 || rx_perr !== 1'b1 || rx_ferr !== 1'b0)
            begin errors++; $display("FAIL 7e1_perr: v=%b d=%h p=%b f=%b want 1/53/1/0", rx_valid, rx_data, rx_perr, rx_ferr); end
        pop_byte();
    endtask

    task automatic test_back_to_back();
        bit ok, bad, busy_bad;
        logic [7:0] bytes [3];
        logic       par [3];
        logic       e;
        bytes[0] = 8'h3C; bytes[1] = 8'h07; bytes[2] = 8'h81;
        par[0] = 1'b1; par[1] = 1'b0; par[2] = 1'b1;
        cfg = 5'b11011; loop = 1'b1;
        for (int f = 0; f < 3; f++) push_byte(bytes[f]);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_after_push: got %b want 1", tx_busy); end
        wait_tx_start("b2b_start", ok);
        if (ok) begin
            busy_bad = 1'b0;
            for (int f = 0; f < 3; f++) begin
                bad = 1'b0;
                for (int b = 0; b < 12; b++) begin
                    if (b == 0) e = 1'b0;
                    else if (b <= 8) e = bytes[f][b-1];
                    else if (b == 9) e = par[f];
                    else e = 1'b1;
                    for (int c = 0; c < 16; c++) begin
                        if (tx_sn !== e) bad = 1'b1;
                        if (tx_busy !== 1'b1) busy_bad = 1'b1;
                        @(negedge clk);
                    end
                end
                checks++; if (bad) begin errors++; $display("FAIL b2b_frame%0d: wire differs from 8O2 frame of %h", f, bytes[f]); end
            end
            checks++; if (busy_bad) begin errors++; $display("FAIL b2b_busy: tx_busy dropped mid-stream, want 1"); end
            checks++; if (tx_busy !== 1'b0 || tx_sn !== 1'b1)
                begin errors++; $display("FAIL b2b_end: busy=%b sn=%b want 0/1", tx_busy, tx_sn); end
        end
        for (int f = 0; f < 3; f++) begin
            checks++; if (rx_valid !== 1'b1 || rx_data !== bytes[f] || rx_perr !== 1'b0)
                begin errors++; $display("FAIL b2b_rx%0d: v=%b d=%h p=%b want 1/%h/0", f, rx_valid, rx_data, rx_perr, bytes[f]); end
            pop_byte();
        end
    endtask

    task automatic test_false_start_ferr();
        cfg = 5'b00011; loop = 1'b0;
        rx_drv = 1'b0; tick(4);
        rx_drv = 1'b1; tick(40);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL false_start: rx_valid=%b want 0", rx_valid); end
        rx_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_ferr !== 1'b1 || rx_perr !== 1'b0)
            begin errors++; $display("FAIL ferr: v=%b d=%h f=%b p=%b want 1/5a/1/0", rx_valid, rx_data, rx_ferr, rx_perr); end
        pop_byte();
        tick(16);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_no_extra: rx_valid=%b want 0", rx_valid); end
    endtask

    task automatic test_overrun();
        cfg = 5'b00011; loop = 1'b0; rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) rx_frame(8'(i), 8, 1'b0, 1'b0, 1'b1);
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_at_full: got %b want 0", rx_overrun); end
        rx_frame(8'h05, 8, 1'b0, 1'b0, 1'b1);
        checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", rx_overrun); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (rx_valid !== 1'b1 || rx_data !== 8'(i))
                begin errors++; $display("FAIL ovr_pop%0d: v=%b d=%h want 1/%h", i, rx_valid, rx_data, 8'(i)); end
            pop_byte();
        end
        checks++; if (rx_valid !== 1'b0 || rx_overrun !== 1'b1)
            begin errors++; $display("FAIL ovr_sticky: v=%b ovr=%b want 0/1", rx_valid, rx_overrun); end
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
    endtask

    task automatic test_reset_mid();
        bit ok, bad;
        cfg = 5'b00011; loop = 1'b1;
        push_byte(8'h00);
        push_byte(8'h00);
        wait_tx_start("rstmid_start", ok);
        tick(40);
        rst_n = 1'b0;
        #1;
        checks++; if (tx_sn !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
            begin errors++; $display("FAIL rstmid_async: sn=%b busy=%b rdy=%b v=%b want 1/0/1/0", tx_sn, tx_busy, tx_ready, rx_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (tx_sn !== 1'b1 || rx_valid !== 1'b0 || tx_busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad) begin errors++; $display("FAIL rstmid_after: saw activity after reset, want idle line and no rx_valid"); end
    endtask

    initial begin
        rst_n = 1'b0; baud_div = 16'd0; cfg = 5'b00011; tx_data = 8'h00;
        tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0; loop = 1'b0; rx_drv = 1'b1;
        @(negedge clk);
        test_reset();
        test_tx_8n1();
        test_7e1();
        test_back_to_back();
        test_false_start_ferr();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
